// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NUM_REQ requesters
// Ports: clk/reset (sync, active-high); req_valid/req_ready + packed req_alu_op/req_in_a/req_in_b per requester;
// alu_op/alu_in_a/alu_in_b out to the shared ALU, alu_result/alu_zero back;
// rsp_valid/rsp_ready handshake with registered rsp_id/rsp_result/rsp_zero.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_alu_op,
  input  logic [32*NUM_REQ-1:0]   req_in_a,
  input  logic [32*NUM_REQ-1:0]   req_in_b,
  output logic [3:0]              alu_op,
  output logic [31:0]             alu_in_a,
  output logic [31:0]             alu_in_b,
  input  logic [31:0]             alu_result,
  input  logic                    alu_zero,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic                    rsp_zero
);
  logic [ID_W-1:0] r_ptr;
  logic            r_valid;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_result;
  logic            r_zero;
  logic [3:0]      w_op [NUM_REQ];
  logic [31:0]     w_a  [NUM_REQ];
  logic [31:0]     w_b  [NUM_REQ];
  logic            w_hit;
  logic [ID_W-1:0] w_g;
  logic            w_issue;
  logic            w_acc;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign w_op[i] = req_alu_op[4*i +: 4];
    assign w_a[i]  = req_in_a[32*i +: 32];
    assign w_b[i]  = req_in_b[32*i +: 32];
    assign req_ready[i] = w_acc && (w_g == ID_W'(i));
  end
  // Scan from the farthest offset down so the one closest to r_ptr wins.
  always_comb begin
    logic [ID_W:0] j;
    w_hit = 1'b0;
    w_g   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      j = {1'b0, r_ptr} + (ID_W+1)'(k);
      j = (j >= (ID_W+1)'(NUM_REQ)) ? j - (ID_W+1)'(NUM_REQ) : j;
      if (req_valid[j[ID_W-1:0]]) begin
        w_hit = 1'b1;
        w_g   = j[ID_W-1:0];
      end
    end
  end
  assign w_issue  = !reset && (!r_valid || rsp_ready);
  assign w_acc    = w_issue && w_hit;
  assign alu_op   = w_hit ? w_op[w_g] : '0;
  assign alu_in_a = w_hit ? w_a[w_g]  : '0;
  assign alu_in_b = w_hit ? w_b[w_g]  : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr    <= '0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_acc) begin
      r_valid  <= 1'b1;
      r_id     <= w_g;
      r_result <= alu_result;
      r_zero   <= alu_zero;
      r_ptr    <= (w_g == ID_W'(NUM_REQ-1)) ? '0 : w_g + 1'b1;
    end else if (rsp_ready) begin
      r_valid  <= 1'b0;
    end
  end
  assign rsp_valid  = r_valid;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) $onehot0(req_ready));
  a_stable: assert property (@(posedge clk) disable iff (reset)
    (r_valid && !rsp_ready) |=> $stable({r_valid, r_id, r_result, r_zero}));
  a_id: assert property (@(posedge clk) {1'b0, r_id} < (ID_W+1)'(NUM_REQ));
`endif
endmodule
